// File: rtl/dm_result_checker_if.sv
// Signal bundle between the DM snoop / golden loader / DM check port and the result checker.
interface dm_result_checker_if #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int GOLD_DEPTH = 64
);
    logic [DATA_W/8-1:0]               dm_web;
    logic [ADDR_W-1:0]                 dm_addr;
    logic [DATA_W-1:0]                 dm_wdata;
    logic                              gold_we;
    logic [$clog2(GOLD_DEPTH)-1:0]     gold_waddr;
    logic [DATA_W-1:0]                 gold_wdata;
    logic [$clog2(GOLD_DEPTH+1)-1:0]   num_golden;
    logic                              chk_re;
    logic [ADDR_W-1:0]                 chk_addr;
    logic [DATA_W-1:0]                 chk_rdata;
    logic                              busy;
    logic                              done;
    logic                              pass;
    logic                              timeout;
    logic [$clog2(GOLD_DEPTH+1)-1:0]   err_cnt;
    logic [ADDR_W-1:0]                 first_err_addr;
    logic [31:0]                       cycle_cnt;

    modport slave (
        input  dm_web, dm_addr, dm_wdata, gold_we, gold_waddr, gold_wdata, num_golden, chk_rdata,
        output chk_re, chk_addr, busy, done, pass, timeout, err_cnt, first_err_addr, cycle_cnt
    );

    modport master (
        output dm_web, dm_addr, dm_wdata, gold_we, gold_waddr, gold_wdata, num_golden, chk_rdata,
        input  chk_re, chk_addr, busy, done, pass, timeout, err_cnt, first_err_addr, cycle_cnt
    );
endinterface

// File: rtl/dm_result_checker.sv
// End-of-test checker: waits for the sim-end code written to DM, then scans DM words through a
// spare read port against a golden table and reports mismatches; a cycle watchdog forces a failed scan.
module dm_result_checker #(
    parameter int                ADDR_W     = 14,
    parameter int                DATA_W     = 32,
    parameter int                GOLD_DEPTH = 64,
    parameter logic [ADDR_W-1:0] END_ADDR   = 14'h3fff,
    parameter logic [DATA_W-1:0] END_CODE   = 32'hFFFF_FFFF,
    parameter logic [ADDR_W-1:0] TEST_START = 14'h0000,
    parameter int                MAX_CYCLES = 300000
) (
    input  logic               clk,
    input  logic               rst,
    dm_result_checker_if.slave bus
);
    localparam int               BYTES   = DATA_W / 8;
    localparam int               GIDX_W  = $clog2(GOLD_DEPTH);
    localparam int               CNT_W   = $clog2(GOLD_DEPTH + 1);
    localparam logic [31:0]      WD_MAX  = 32'(MAX_CYCLES);
    localparam logic [31:0]      WD_LAST = 32'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] N_MAX   = CNT_W'(GOLD_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_shadow;
    logic [31:0]         r_cycle_cnt;
    logic [CNT_W-1:0]    r_n;
    logic [CNT_W-1:0]    r_idx;
    logic                r_cmp_vld;
    logic [GIDX_W-1:0]   r_cmp_idx;
    logic                r_chk_re;
    logic [ADDR_W-1:0]   r_chk_addr;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_err_cnt;
    logic [ADDR_W-1:0]   r_first_err_addr;
    logic [DATA_W-1:0]   r_gold [GOLD_DEPTH];

    logic [DATA_W-1:0]   w_shadow_nxt;
    logic                w_end_hit;
    logic                w_wd_hit;
    logic [CNT_W-1:0]    w_n_lat;
    logic                w_mismatch;
    logic [CNT_W-1:0]    w_err_nxt;
    logic [31:0]         w_cnt_nxt;

    // Byte-merged end-word shadow, watchdog, scan length clamp and compare result.
    always_comb begin
        w_shadow_nxt = r_shadow;
        for (int b = 0; b < BYTES; b++) begin
            if (!bus.dm_web[b] && (bus.dm_addr == END_ADDR)) begin
                w_shadow_nxt[8*b +: 8] = bus.dm_wdata[8*b +: 8];
            end else begin
                w_shadow_nxt[8*b +: 8] = r_shadow[8*b +: 8];
            end
        end
        w_end_hit = (r_state == ST_RUN) && (w_shadow_nxt == END_CODE);
        w_wd_hit  = (r_state == ST_RUN) && (r_cycle_cnt == WD_LAST);
        if (bus.num_golden > N_MAX) begin
            w_n_lat = N_MAX;
        end else begin
            w_n_lat = bus.num_golden;
        end
        w_mismatch = r_cmp_vld && (bus.chk_rdata != r_gold[r_cmp_idx]);
        if (w_mismatch && (r_err_cnt < r_n)) begin
            w_err_nxt = r_err_cnt + CNT_W'(1);
        end else begin
            w_err_nxt = r_err_cnt;
        end
        if (r_cycle_cnt < WD_MAX) begin
            w_cnt_nxt = r_cycle_cnt + 32'd1;
        end else begin
            w_cnt_nxt = r_cycle_cnt;
        end
    end

    // Golden table storage; deliberately not reset so contents survive a checker reset.
    always_ff @(posedge clk) begin
        if ((r_state == ST_RUN) && bus.gold_we) begin
            r_gold[bus.gold_waddr] <= bus.gold_wdata;
        end
    end

    // Checker FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state          <= ST_RUN;
            r_shadow         <= {DATA_W{1'b0}};
            r_cycle_cnt      <= 32'd0;
            r_n              <= {CNT_W{1'b0}};
            r_idx            <= {CNT_W{1'b0}};
            r_cmp_vld        <= 1'b0;
            r_cmp_idx        <= {GIDX_W{1'b0}};
            r_chk_re         <= 1'b0;
            r_chk_addr       <= {ADDR_W{1'b0}};
            r_busy           <= 1'b0;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_timeout        <= 1'b0;
            r_err_cnt        <= {CNT_W{1'b0}};
            r_first_err_addr <= {ADDR_W{1'b0}};
        end else begin
            r_err_cnt <= w_err_nxt;
            if (w_mismatch && (r_err_cnt == {CNT_W{1'b0}})) begin
                r_first_err_addr <= TEST_START + ADDR_W'(r_cmp_idx);
            end
            case (r_state)
                ST_RUN: begin
                    r_shadow    <= w_shadow_nxt;
                    r_cycle_cnt <= w_cnt_nxt;
                    if (w_end_hit || w_wd_hit) begin
                        r_timeout <= !w_end_hit;
                        r_n       <= w_n_lat;
                        r_idx     <= {CNT_W{1'b0}};
                        r_busy    <= 1'b1;
                        if (w_n_lat == {CNT_W{1'b0}}) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state    <= ST_SCAN;
                            r_chk_re   <= 1'b1;
                            r_chk_addr <= TEST_START;
                        end
                    end
                end
                ST_SCAN: begin
                    r_cmp_vld <= 1'b1;
                    r_cmp_idx <= r_idx[GIDX_W-1:0];
                    if (r_idx == (r_n - CNT_W'(1))) begin
                        r_state  <= ST_DRAIN;
                        r_chk_re <= 1'b0;
                    end else begin
                        r_idx      <= r_idx + CNT_W'(1);
                        r_chk_addr <= TEST_START + ADDR_W'(r_idx + CNT_W'(1));
                    end
                end
                ST_DRAIN: begin
                    r_cmp_vld <= 1'b0;
                    r_state   <= ST_DONE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_pass    <= (w_err_nxt == {CNT_W{1'b0}}) && !r_timeout;
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_DONE;
                end
            endcase
        end
    end

    assign bus.chk_re         = r_chk_re;
    assign bus.chk_addr       = r_chk_addr;
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.timeout        = r_timeout;
    assign bus.err_cnt        = r_err_cnt;
    assign bus.first_err_addr = r_first_err_addr;
    assign bus.cycle_cnt      = r_cycle_cnt;
endmodule

// File: tb/tb_dm_result_checker.sv
// Self-checking bench for dm_result_checker: DM memory model on the check port, vector table,
// directed corner sequences and randomized scans against a counting reference model.
module tb_dm_result_checker;
    localparam int          MAXC  = 200;
    localparam int          GD    = 64;
    localparam logic [13:0] END_A = 14'h3fff;

    typedef struct {
        int          n;
        logic [63:0] mask;
        int          exp_err;
        int          exp_first;
        int          exp_pass;
    } vec_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          nchecks = 0;
    int          nerrors = 0;
    int          cyc = 0;
    int          e0_cyc = 0;
    int          rd_cnt = 0;
    int          rd_base = 0;
    logic [31:0] g      [GD];
    logic [31:0] dm_mem [GD];
    vec_t        vecs   [8];

    dm_result_checker_if #(.ADDR_W(14), .DATA_W(32), .GOLD_DEPTH(GD)) bus ();

    dm_result_checker #(
        .ADDR_W(14), .DATA_W(32), .GOLD_DEPTH(GD),
        .END_ADDR(14'h3fff), .END_CODE(32'hFFFF_FFFF), .TEST_START(14'h0000),
        .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk),
        .rst(rst_n),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // DM check-port model: one-cycle read latency
    always @(posedge clk) begin
        if (bus.chk_re) begin
            bus.chk_rdata <= (bus.chk_addr < 14'd64) ? dm_mem[bus.chk_addr[5:0]] : 32'hDEAD_BEEF;
            rd_cnt <= rd_cnt + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        bus.dm_web     = 4'hF;
        bus.dm_addr    = 14'h0000;
        bus.dm_wdata   = 32'h0;
        bus.gold_we    = 1'b0;
        bus.gold_waddr = 6'd0;
        bus.gold_wdata = 32'h0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle();
        #1;
        check("rst.busy", bus.busy, 1'b0);
        check("rst.done", bus.done, 1'b0);
        check("rst.pass", bus.pass, 1'b0);
        check("rst.timeout", bus.timeout, 1'b0);
        check("rst.chk_re", bus.chk_re, 1'b0);
        check("rst.chk_addr", bus.chk_addr, 14'h0);
        check("rst.err_cnt", bus.err_cnt, 7'd0);
        check("rst.first_err", bus.first_err_addr, 14'h0);
        check("rst.cycle_cnt", bus.cycle_cnt, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic set_dm(input logic [63:0] mask);
        for (int i = 0; i < GD; i++) begin
            dm_mem[i] = mask[i] ? (g[i] ^ 32'h0001_8000) : g[i];
        end
    endtask

    task automatic load_golden();
        for (int i = 0; i < GD; i++) begin
            bus.gold_we    = 1'b1;
            bus.gold_waddr = 6'(i);
            bus.gold_wdata = g[i];
            step();
        end
        bus.gold_we = 1'b0;
    endtask

    task automatic end_write(input logic [31:0] data, input logic [3:0] web);
        bus.dm_addr  = END_A;
        bus.dm_wdata = data;
        bus.dm_web   = web;
        rd_base      = rd_cnt;
        step();
        e0_cyc = cyc;
        idle();
    endtask

    task automatic finish_check(input string tag, input int n, input int exp_err,
                                input int exp_first, input int exp_pass, input int exp_to);
        int neff;
        int k;
        neff = (n > GD) ? GD : n;
        k = 0;
        bus.num_golden = 7'($urandom_range(0, 127));
        check($sformatf("%s.busy", tag), bus.busy, 1'b1);
        while (!bus.done && k < 300) begin
            step();
            k++;
        end
        check($sformatf("%s.latency", tag), 64'(k + 1), 64'(neff + 2));
        check($sformatf("%s.err_cnt", tag), bus.err_cnt, 64'(exp_err));
        check($sformatf("%s.first_err", tag), bus.first_err_addr, 64'(exp_first));
        check($sformatf("%s.pass", tag), bus.pass, 64'(exp_pass));
        check($sformatf("%s.timeout", tag), bus.timeout, 64'(exp_to));
        check($sformatf("%s.busy_end", tag), bus.busy, 1'b0);
        check($sformatf("%s.chk_re_end", tag), bus.chk_re, 1'b0);
        check($sformatf("%s.cycle_cnt", tag), bus.cycle_cnt, 64'((e0_cyc > MAXC) ? MAXC : e0_cyc));
        check($sformatf("%s.reads", tag), 64'(rd_cnt - rd_base), 64'(neff));
    endtask

    initial begin
        int          n;
        int          exp_err;
        int          exp_first;
        int          neff;
        int          k;
        logic [63:0] mask;

        vecs[0] = '{4,   64'h0,                    0,  0,  1};
        vecs[1] = '{4,   64'h4,                    1,  2,  0};
        vecs[2] = '{8,   64'hA2,                   3,  1,  0};
        vecs[3] = '{4,   64'h40,                   0,  0,  1};
        vecs[4] = '{100, 64'h8000_0000_0000_0000, 1,  63, 0};
        vecs[5] = '{1,   64'h1,                    1,  0,  0};
        vecs[6] = '{0,   64'hFFFF,                 0,  0,  1};
        vecs[7] = '{64,  64'hFFFF_FFFF_FFFF_FFFF, 64, 0,  0};

        for (int i = 0; i < GD; i++) begin
            g[i] = $urandom;
        end
        bus.num_golden = 7'd0;
        bus.chk_rdata  = 32'h0;
        idle();
        apply_reset();
        load_golden();

        for (int v = 0; v < 8; v++) begin
            if (v > 0) begin
                apply_reset();
            end
            set_dm(vecs[v].mask);
            bus.num_golden = 7'(vecs[v].n);
            end_write(32'hFFFF_FFFF, 4'h0);
            finish_check($sformatf("vec%0d", v), vecs[v].n, vecs[v].exp_err,
                         vecs[v].exp_first, vecs[v].exp_pass, 0);
        end

        // Byte-wise completion of the end code; partial words must not end the run.
        apply_reset();
        set_dm(64'h0);
        bus.num_golden = 7'd3;
        for (int b = 0; b < 3; b++) begin
            end_write(32'hFF << (8 * b), 4'(~(4'b0001 << b)));
            check($sformatf("t3.byte%0d_busy", b), bus.busy, 1'b0);
        end
        end_write(32'hFF00_0000, 4'h7);
        finish_check("t3.bytes", 3, 0, 0, 1, 0);

        apply_reset();
        bus.num_golden = 7'd3;
        end_write(32'hFFFF_FF00, 4'h0);
        step();
        check("t3.partial_busy", bus.busy, 1'b0);
        end_write(32'h0000_00FF, 4'hE);
        finish_check("t3.complete", 3, 0, 0, 1, 0);

        // Watchdog: no end code, scan still runs but result fails.
        apply_reset();
        set_dm(64'h0);
        bus.num_golden = 7'd4;
        rd_base = rd_cnt;
        k = 0;
        while (!bus.busy && k < 300) begin
            step();
            k++;
        end
        e0_cyc = cyc;
        check("t4.wd_cycle", 64'(k), 64'(MAXC));
        check("t4.timeout_early", bus.timeout, 1'b1);
        finish_check("t4", 4, 0, 0, 0, 1);

        // End code on the last watchdog cycle wins over timeout.
        apply_reset();
        bus.num_golden = 7'd0;
        repeat (MAXC - 1) step();
        check("t5.cycle_cnt_pre", bus.cycle_cnt, 64'(MAXC - 1));
        end_write(32'hFFFF_FFFF, 4'h0);
        finish_check("t5", 0, 0, 0, 1, 0);

        // Reset mid-scan, then golden writes after done must be ignored.
        apply_reset();
        set_dm(64'h0);
        bus.num_golden = 7'd20;
        end_write(32'hFFFF_FFFF, 4'h0);
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        check("t6.busy", bus.busy, 1'b0);
        check("t6.chk_re", bus.chk_re, 1'b0);
        check("t6.chk_addr", bus.chk_addr, 14'h0);
        check("t6.cycle_cnt", bus.cycle_cnt, 32'd0);
        step();
        rst_n = 1'b1;
        cyc = 0;
        repeat (10) step();
        check("t6.no_restart", bus.busy, 1'b0);
        check("t6.cycle_run", bus.cycle_cnt, 32'd10);
        bus.num_golden = 7'd2;
        end_write(32'hFFFF_FFFF, 4'h0);
        finish_check("t6.run", 2, 0, 0, 1, 0);
        bus.gold_we    = 1'b1;
        bus.gold_waddr = 6'd0;
        bus.gold_wdata = ~g[0];
        step();
        bus.gold_we = 1'b0;
        check("t6.done_sticky", bus.done, 1'b1);
        apply_reset();
        bus.num_golden = 7'd1;
        end_write(32'hFFFF_FFFF, 4'h0);
        finish_check("t6.gold", 1, 0, 0, 1, 0);

        // Randomized scans against a counting reference model.
        for (int it = 0; it < 20; it++) begin
            apply_reset();
            mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            n = $urandom_range(0, 72);
            set_dm(mask);
            bus.num_golden = 7'(n);
            neff = (n > GD) ? GD : n;
            exp_err = 0;
            exp_first = 0;
            for (int i = 0; i < neff; i++) begin
                if (dm_mem[i] != g[i]) begin
                    if (exp_err == 0) begin
                        exp_first = i;
                    end
                    exp_err++;
                end
            end
            repeat ($urandom_range(0, 15)) step();
            if ($urandom_range(0, 1) == 1) begin
                end_write(32'hFFFF_FFFF, 4'h0);
            end else begin
                for (int b = 0; b < 4; b++) begin
                    end_write(32'hFF << (8 * b), 4'(~(4'b0001 << b)));
                end
            end
            finish_check($sformatf("rnd%0d", it), n, exp_err, exp_first,
                         (exp_err == 0) ? 1 : 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end
endmodule
